// File: rtl/tt_bus_responder.sv
// tt_bus_responder: register-file responder on the tile pin bus using a 4-phase strobe/ack handshake.
// Define TTBUS_PARITY_EN to enable write-parity checking and the rdata parity bit on uo_out[2].
module tt_bus_responder #(
  parameter logic [7:0] ID_VALUE    = 8'hA5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ACK  = 2'd2
  } state_t;

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  state_t                 state_r;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   strb_s;
  logic [3:0]             addr_r;
  logic                   wr_r;
  logic                   par_r;
  logic [7:0]             wdata_r;
  logic                   ack_r;
  logic                   err_r;
  logic                   busy_r;
  logic [7:0]             rdata_r;
  logic [7:0]             oe_r;
  logic [7:0]             scratch_r [8];
  logic [15:0]            cnt16_r;
  logic [7:0]             shadow_r;
  logic [7:0]             txn_r;

  logic [7:0]             rd_data_s;
  logic                   err_set_s;
  logic                   scr_we_s;
  logic                   cnt_clr_s;
  logic                   txn_clr_s;
  logic                   shadow_ld_s;
  logic                   par_ok_s;
  logic                   unused_s;

  assign strb_s   = sync_r[SYNC_STAGES-1];
  assign unused_s = ^{ui_in[4], par_r};

  // Strobe synchronizer: strb is the only input that crosses from the host domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], ui_in[7]};
    end
  end

  // Decode of the captured transaction, consumed during EXEC.
  always_comb begin
    rd_data_s   = 8'h00;
    err_set_s   = 1'b0;
    scr_we_s    = 1'b0;
    cnt_clr_s   = 1'b0;
    txn_clr_s   = 1'b0;
    shadow_ld_s = 1'b0;
`ifdef TTBUS_PARITY_EN
    par_ok_s    = (even_par(wdata_r) == par_r);
`else
    par_ok_s    = 1'b1;
`endif
    if (wr_r) begin
      if (!par_ok_s) begin
        err_set_s = 1'b1;
      end else begin
        case (addr_r)
          4'h0, 4'h1, 4'h2, 4'h3,
          4'h4, 4'h5, 4'h6, 4'h7: scr_we_s  = 1'b1;
          4'h9:                   cnt_clr_s = 1'b1;
          4'hB:                   txn_clr_s = 1'b1;
          default:                err_set_s = 1'b1;
        endcase
      end
    end else begin
      case (addr_r)
        4'h0, 4'h1, 4'h2, 4'h3,
        4'h4, 4'h5, 4'h6, 4'h7: rd_data_s = scratch_r[addr_r[2:0]];
        4'h8:                   rd_data_s = ID_VALUE;
        4'h9: begin
          rd_data_s   = cnt16_r[7:0];
          shadow_ld_s = 1'b1;
        end
        4'hA:                   rd_data_s = shadow_r;
        4'hB:                   rd_data_s = txn_r;
        default:                err_set_s = 1'b1;
      endcase
    end
  end

  // Handshake FSM, register file and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      addr_r   <= 4'h0;
      wr_r     <= 1'b0;
      par_r    <= 1'b0;
      wdata_r  <= 8'h00;
      ack_r    <= 1'b0;
      err_r    <= 1'b0;
      busy_r   <= 1'b0;
      rdata_r  <= 8'h00;
      oe_r     <= 8'h00;
      cnt16_r  <= 16'h0000;
      shadow_r <= 8'h00;
      txn_r    <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        scratch_r[i] <= 8'h00;
      end
    end else begin
      if (ena) begin
        cnt16_r <= cnt16_r + 16'd1;
      end else begin
        cnt16_r <= cnt16_r;
      end
      if (!ena) begin
        // Dropping ena abandons any transaction, including one about to execute.
        state_r <= IDLE;
        ack_r   <= 1'b0;
        oe_r    <= 8'h00;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (strb_s) begin
              addr_r  <= ui_in[3:0];
              wr_r    <= ui_in[6];
              par_r   <= ui_in[5];
              wdata_r <= uio_in;
              state_r <= EXEC;
              busy_r  <= 1'b1;
            end
          end
          EXEC: begin
            if (scr_we_s) begin
              scratch_r[addr_r[2:0]] <= wdata_r;
            end
            if (cnt_clr_s) begin
              cnt16_r <= 16'h0000;
            end
            if (shadow_ld_s) begin
              shadow_r <= cnt16_r[15:8];
            end
            if (!wr_r) begin
              rdata_r <= rd_data_s;
            end
            if (txn_clr_s) begin
              txn_r <= 8'h00;
              err_r <= 1'b0;
            end else begin
              txn_r <= txn_r + 8'd1;
              err_r <= err_r | err_set_s;
            end
            oe_r    <= wr_r ? 8'h00 : 8'hFF;
            ack_r   <= 1'b1;
            state_r <= ACK;
          end
          ACK: begin
            if (!strb_s) begin
              state_r <= IDLE;
              ack_r   <= 1'b0;
              oe_r    <= 8'h00;
              busy_r  <= 1'b0;
            end
          end
          default: begin
            state_r <= IDLE;
            ack_r   <= 1'b0;
            oe_r    <= 8'h00;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef TTBUS_PARITY_EN
  assign uo_out = {txn_r[4:0], even_par(rdata_r), err_r, ack_r};
`else
  assign uo_out = {txn_r[4:0], busy_r, err_r, ack_r};
`endif
  assign uio_out = rdata_r;
  assign uio_oe  = oe_r;

endmodule

// File: tb/tb_tt_bus_responder.sv
// Self-checking bench for tt_bus_responder: vector table, scoreboard queue and hand-written corner sequences.
module tb_tt_bus_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] txn_m    = 8'h00;
  logic [7:0] last_rd  = 8'h00;
  logic       rd_known = 1'b1;

  typedef struct {
    logic       chk_data;
    logic [7:0] data;
    logic [7:0] oe;
    logic       err;
    logic [4:0] txn;
    logic       chk_b2;
    logic       b2;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic       w;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;
  vec_t vt[20];

  tt_bus_responder dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Parity driven with writes: correct when the feature is built in, deliberately wrong otherwise.
  function automatic logic par_for(input logic [7:0] d);
`ifdef TTBUS_PARITY_EN
    return ^d;
`else
    return ~(^d);
`endif
  endfunction

  function automatic logic par_good(input logic [7:0] d, input logic p);
`ifdef TTBUS_PARITY_EN
    return (p == ^d);
`else
    return 1'b1;
`endif
  endfunction

  task automatic xact(input logic w, input logic [3:0] a, input logic [7:0] d, input logic p,
                      input logic chk_data, input logic [7:0] exp_data, input logic exp_err,
                      output logic [7:0] rd);
    exp_t e;
    int   n;
    if (w && a == 4'hB && par_good(d, p)) txn_m = 8'h00;
    else txn_m = txn_m + 8'd1;
    if (!w) begin
      rd_known = chk_data;
      last_rd  = exp_data;
    end
    e.chk_data = chk_data && !w;
    e.data     = exp_data;
    e.oe       = w ? 8'h00 : 8'hFF;
    e.err      = exp_err;
    e.txn      = txn_m[4:0];
`ifdef TTBUS_PARITY_EN
    e.chk_b2   = rd_known;
    e.b2       = ^last_rd;
`else
    e.chk_b2   = 1'b1;
    e.b2       = 1'b1;
`endif
    @(negedge clk);
    ui_in  = {1'b1, w, p, 1'b0, a};
    uio_in = d;
    sb.push_back(e);
    n = 0;
    while (uo_out[0] !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("ack_latency@%0h", a), n, 4);
    e = sb.pop_front();
    if (e.chk_data) chk($sformatf("rdata@%0h", a), uio_out, e.data);
    chk($sformatf("oe@%0h", a), uio_oe, e.oe);
    chk($sformatf("err@%0h", a), uo_out[1], e.err);
    chk($sformatf("txn@%0h", a), uo_out[7:3], e.txn);
    if (e.chk_b2) chk($sformatf("bit2@%0h", a), uo_out[2], e.b2);
    rd = uio_out;
    @(negedge clk);
    ui_in[7] = 1'b0;
    n = 0;
    while (uo_out[0] !== 1'b0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("ack_release@%0h", a), n, 3);
    chk($sformatf("oe_release@%0h", a), uio_oe, 8'h00);
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       seen;

    vt[0]  = '{1'b0, 4'h8, 8'h00, 8'hA5, 1'b0};
    vt[1]  = '{1'b1, 4'h5, 8'h3C, 8'h00, 1'b0};
    vt[2]  = '{1'b0, 4'h5, 8'h00, 8'h3C, 1'b0};
    vt[3]  = '{1'b0, 4'h0, 8'h00, 8'h00, 1'b0};
    vt[4]  = '{1'b0, 4'h7, 8'h00, 8'h00, 1'b0};
    vt[5]  = '{1'b0, 4'h4, 8'h00, 8'h00, 1'b0};
    vt[6]  = '{1'b1, 4'h0, 8'h11, 8'h00, 1'b0};
    vt[7]  = '{1'b0, 4'h0, 8'h00, 8'h11, 1'b0};
    vt[8]  = '{1'b0, 4'hD, 8'h00, 8'h00, 1'b1};
    vt[9]  = '{1'b1, 4'h2, 8'h77, 8'h00, 1'b1};
    vt[10] = '{1'b0, 4'h2, 8'h00, 8'h77, 1'b1};
    vt[11] = '{1'b1, 4'h8, 8'hFF, 8'h00, 1'b1};
    vt[12] = '{1'b0, 4'h8, 8'h00, 8'hA5, 1'b1};
    vt[13] = '{1'b1, 4'hB, 8'h5A, 8'h00, 1'b0};
    vt[14] = '{1'b0, 4'hB, 8'h00, 8'h00, 1'b0};
    vt[15] = '{1'b1, 4'hA, 8'h01, 8'h00, 1'b1};
    vt[16] = '{1'b1, 4'hC, 8'h00, 8'h00, 1'b1};
    vt[17] = '{1'b0, 4'hF, 8'h00, 8'h00, 1'b1};
    vt[18] = '{1'b1, 4'hB, 8'h00, 8'h00, 1'b0};
    vt[19] = '{1'b0, 4'h5, 8'h00, 8'h3C, 1'b0};

    rst    = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_uo_out", uo_out, 8'h00);
    chk("reset_uio_out", uio_out, 8'h00);
    chk("reset_uio_oe", uio_oe, 8'h00);

    for (int i = 0; i < 20; i++) begin
      xact(vt[i].w, vt[i].a, vt[i].d, par_for(vt[i].d), ~vt[i].w, vt[i].exp_rd, vt[i].exp_err, rd);
    end

    // Cycle counter: clear, wait, read low byte then the snapshotted high byte.
    xact(1'b1, 4'h9, 8'h00, par_for(8'h00), 1'b0, 8'h00, 1'b0, rd);
    repeat (300) @(posedge clk);
    xact(1'b0, 4'h9, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, lo);
    xact(1'b0, 4'hA, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, hi);
    chk_range("cnt_after_300", {hi, lo}, 300, 311);
    // Chosen so the live count crosses 0x100 between the two reads while the snapshot does not.
    xact(1'b1, 4'h9, 8'hAB, par_for(8'hAB), 1'b0, 8'h00, 1'b0, rd);
    repeat (244) @(posedge clk);
    xact(1'b0, 4'h9, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, lo);
    xact(1'b0, 4'hA, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, hi);
    chk_range("cnt_snapshot", {hi, lo}, 244, 255);

    // Drop ena once EXEC has been entered: the write to scratch 3 must not happen.
    @(negedge clk);
    ui_in  = {1'b1, 1'b1, par_for(8'h99), 1'b0, 4'h3};
    uio_in = 8'h99;
    repeat (3) @(posedge clk);
    @(negedge clk);
`ifndef TTBUS_PARITY_EN
    chk("exec_busy", uo_out[2], 1'b1);
`endif
    ena = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_ack", uo_out[0], 1'b0);
    chk("abort_oe", uio_oe, 8'h00);
`ifndef TTBUS_PARITY_EN
    chk("abort_busy", uo_out[2], 1'b0);
`endif
    chk("abort_txn", uo_out[7:3], txn_m[4:0]);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (uo_out[0] === 1'b1) seen = 1'b1;
    end
    chk("abort_no_ack", seen, 1'b0);
    @(negedge clk);
    ui_in[7] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    ena = 1'b1;
    xact(1'b0, 4'h3, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, rd);

`ifdef TTBUS_PARITY_EN
    xact(1'b1, 4'h1, 8'h07, 1'b0, 1'b0, 8'h00, 1'b1, rd);
    xact(1'b0, 4'h1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, rd);
    xact(1'b1, 4'hB, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, rd);
    xact(1'b1, 4'h1, 8'h07, 1'b1, 1'b0, 8'h00, 1'b0, rd);
    xact(1'b0, 4'h1, 8'h00, 1'b0, 1'b1, 8'h07, 1'b0, rd);
`endif

    // Transaction counter wrap: 255 reads after a clear, then TXN reads 0xFF and wraps to 0x00.
    xact(1'b1, 4'hB, 8'h00, par_for(8'h00), 1'b0, 8'h00, 1'b0, rd);
    for (int i = 0; i < 255; i++) begin
      xact(1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, rd);
    end
    xact(1'b0, 4'hB, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, rd);
    xact(1'b0, 4'hB, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, rd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
